// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU checker, its interface and the
// reference model.
//   alu_op_t    - ALU operation encoding (AND, ADD, XOR, SUB)
//   chk_state_t - checker FSM states
//   DATA_W      - ALU data width
//   SETTLE_W    - settle counter width; it holds SETTLE_CYCLES-1 for 1..15
package alu_pkg;

  localparam int DATA_W   = 8;
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_ADD = 2'b01,
    OP_XOR = 2'b10,
    OP_SUB = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_CHECK  = 2'b10
  } chk_state_t;

endpackage

// File: rtl/alu_checker_if.sv
// alu_checker_if: bundles the operand handshake, the ALU result under check,
// the clear request and the checker status outputs.
//   master - the operand driver / bench side. It drives the operands, Result,
//            Zero and Clear, and it observes the status outputs.
//   slave  - the checker side.
// CNT_W must match the CNT_W of the checker that is attached.
interface alu_checker_if
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic              InValid;
  logic              InReady;
  alu_op_t           ALUOp;
  logic [DATA_W-1:0] ALUSrcA;
  logic [DATA_W-1:0] ALUSrcB;
  logic [DATA_W-1:0] Result;
  logic              Zero;
  logic              Clear;
  logic              CheckValid;
  logic              Mismatch;
  logic [DATA_W-1:0] Expected;
  logic [CNT_W-1:0]  CheckCount;
  logic [CNT_W-1:0]  ErrCount;
  logic              FirstErrValid;
  alu_op_t           FirstErrOp;

  modport master (
    output InValid, ALUOp, ALUSrcA, ALUSrcB, Result, Zero, Clear,
    input  InReady, CheckValid, Mismatch, Expected, CheckCount, ErrCount,
           FirstErrValid, FirstErrOp
  );

  modport slave (
    input  InValid, ALUOp, ALUSrcA, ALUSrcB, Result, Zero, Clear,
    output InReady, CheckValid, Mismatch, Expected, CheckCount, ErrCount,
           FirstErrValid, FirstErrOp
  );

endinterface

// File: rtl/alu_ref_model.sv
// alu_ref_model: purely combinational golden model of the ALU.
//   op     - operation (alu_op_t)
//   a, b   - operands
//   result - expected result. ADD and SUB wrap modulo 2^DATA_W, so the
//            carry and the borrow are dropped.
//   zero   - expected zero flag (result == 0)
// The ALU test scoreboard uses this model as well.
module alu_ref_model
  import alu_pkg::*;
(
  input  alu_op_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      OP_AND:  result = a & b;
      OP_ADD:  result = a + b;
      OP_XOR:  result = a ^ b;
      OP_SUB:  result = a - b;
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_checker.sv
// alu_checker: a self-checking monitor on the ALU operand/result interface.
// It accepts an (ALUOp, ALUSrcA, ALUSrcB) triple through a valid/ready
// handshake and waits SETTLE_CYCLES cycles. It then compares the live
// Result/Zero against alu_ref_model and keeps saturating statistics.
// Ports:
//   Clk    - system clock, rising edge
//   ResetN - asynchronous active-low reset; it discards any check in flight
//   bus    - alu_checker_if slave modport:
//            handshake : InValid, InReady
//            operands  : ALUOp, ALUSrcA, ALUSrcB
//            ALU result: Result, Zero
//            control   : Clear
//            status    : CheckValid, Mismatch, Expected, CheckCount,
//                        ErrCount, FirstErrValid, FirstErrOp
// Parameters:
//   SETTLE_CYCLES - number of cycles spent in SETTLE (1..15)
//   CNT_W         - width of CheckCount and ErrCount
module alu_checker
  import alu_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
)(
  input  logic          Clk,
  input  logic          ResetN,
  alu_checker_if.slave  bus
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

  chk_state_t          state_reg;
  logic [SETTLE_W-1:0] settle_cnt_reg;
  alu_op_t             op_reg;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;

  logic                in_ready_reg;
  logic                check_valid_reg;
  logic                mismatch_reg;
  logic [DATA_W-1:0]   expected_reg;
  logic [CNT_W-1:0]    check_count_reg;
  logic [CNT_W-1:0]    err_count_reg;
  logic                first_err_valid_reg;
  alu_op_t             first_err_op_reg;

  logic [DATA_W-1:0]   ref_result;
  logic                ref_zero;
  logic                mismatch_now;

  // The reference is computed from the latched triple. Result and Zero are
  // live, and the registers below only consume mismatch_now in CHECK.
  alu_ref_model u_ref (
    .op     (op_reg),
    .a      (a_reg),
    .b      (b_reg),
    .result (ref_result),
    .zero   (ref_zero)
  );

  assign mismatch_now = (bus.Result != ref_result) || (bus.Zero != ref_zero);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_reg           <= ST_IDLE;
      settle_cnt_reg      <= '0;
      op_reg              <= OP_AND;
      a_reg               <= '0;
      b_reg               <= '0;
      in_ready_reg        <= 1'b1;
      check_valid_reg     <= 1'b0;
      mismatch_reg        <= 1'b0;
      expected_reg        <= '0;
      check_count_reg     <= '0;
      err_count_reg       <= '0;
      first_err_valid_reg <= 1'b0;
      first_err_op_reg    <= OP_AND;
    end else begin
      check_valid_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (bus.InValid) begin
            op_reg         <= bus.ALUOp;
            a_reg          <= bus.ALUSrcA;
            b_reg          <= bus.ALUSrcB;
            settle_cnt_reg <= SETTLE_LOAD;
            in_ready_reg   <= 1'b0;
            state_reg      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_reg == '0) begin
            state_reg <= ST_CHECK;
          end else begin
            settle_cnt_reg <= settle_cnt_reg - 1'b1;
          end
        end
        ST_CHECK: begin
          // Ready comes back together with the pulse, so a driver that holds
          // InValid high is accepted in the same cycle as CheckValid.
          check_valid_reg <= 1'b1;
          mismatch_reg    <= mismatch_now;
          expected_reg    <= ref_result;
          in_ready_reg    <= 1'b1;
          state_reg       <= ST_IDLE;
        end
        default: begin
          in_ready_reg <= 1'b1;
          state_reg    <= ST_IDLE;
        end
      endcase

      // Clear takes priority over a check that completes on the same edge.
      // The pulse above is still produced, but the statistics stay cleared.
      if (bus.Clear) begin
        check_count_reg     <= '0;
        err_count_reg       <= '0;
        first_err_valid_reg <= 1'b0;
        first_err_op_reg    <= OP_AND;
      end else if (state_reg == ST_CHECK) begin
        if (check_count_reg != CNT_MAX) begin
          check_count_reg <= check_count_reg + 1'b1;
        end
        if (mismatch_now) begin
          if (err_count_reg != CNT_MAX) begin
            err_count_reg <= err_count_reg + 1'b1;
          end
          if (!first_err_valid_reg) begin
            first_err_valid_reg <= 1'b1;
            first_err_op_reg    <= op_reg;
          end
        end
      end
    end
  end

  assign bus.InReady       = in_ready_reg;
  assign bus.CheckValid    = check_valid_reg;
  assign bus.Mismatch      = mismatch_reg;
  assign bus.Expected      = expected_reg;
  assign bus.CheckCount    = check_count_reg;
  assign bus.ErrCount      = err_count_reg;
  assign bus.FirstErrValid = first_err_valid_reg;
  assign bus.FirstErrOp    = first_err_op_reg;

endmodule

// File: tb/tb_alu_checker.sv
// tb_alu_checker: randomized, self-checking bench for alu_checker.
// It uses two instances: dut_a (SETTLE_CYCLES=2, CNT_W=8) and dut_b
// (SETTLE_CYCLES=1, CNT_W=3). The bench predicts every output from the ALU
// arithmetic rules and from the saturating and clear rules of the checker.
// Latency is counted from the handshake cycle. That cycle is cycle 0, and
// CheckValid is expected high in cycle SETTLE_CYCLES+2.
module tb_alu_checker;
  import alu_pkg::*;

  typedef struct packed {
    logic       ready;
    logic       cv;
    logic       mis;
    logic [7:0] expd;
    logic [7:0] cnt;
    logic [7:0] err;
    logic       fv;
    logic [1:0] fop;
  } obs_t;

  logic Clk    = 1'b0;
  logic ResetN = 1'b0;
  always #5 Clk = ~Clk;

  alu_checker_if #(.CNT_W(8)) bus_a ();
  alu_checker_if #(.CNT_W(3)) bus_b ();

  alu_checker #(.SETTLE_CYCLES(2), .CNT_W(8)) dut_a (.Clk(Clk), .ResetN(ResetN), .bus(bus_a));
  alu_checker #(.SETTLE_CYCLES(1), .CNT_W(3)) dut_b (.Clk(Clk), .ResetN(ResetN), .bus(bus_b));

  int n_vec  = 0;
  int n_fail = 0;

  int         settle  [2] = '{2, 1};
  int         cnt_max [2] = '{255, 7};
  int         m_cnt   [2];
  int         m_err   [2];
  bit         m_fv    [2];
  logic [1:0] m_fop   [2];

  // Golden ALU built from plain integer arithmetic.
  function automatic logic [7:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia;
    int ib;
    int r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'd0:    r = ia & ib;
      2'd1:    r = (ia + ib) % 256;
      2'd2:    r = ia ^ ib;
      default: r = (ia - ib + 256) % 256;
    endcase
    return 8'(r);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0;
      m_err[s] = 0;
      m_fv[s]  = 1'b0;
      m_fop[s] = 2'b00;
    end
  endtask

  task automatic model_check(input int sel, input logic [1:0] op, input bit mis, input bit clr);
    if (clr) begin
      m_cnt[sel] = 0;
      m_err[sel] = 0;
      m_fv[sel]  = 1'b0;
      m_fop[sel] = 2'b00;
    end else begin
      m_cnt[sel] = (m_cnt[sel] < cnt_max[sel]) ? m_cnt[sel] + 1 : cnt_max[sel];
      if (mis) begin
        m_err[sel] = (m_err[sel] < cnt_max[sel]) ? m_err[sel] + 1 : cnt_max[sel];
        if (!m_fv[sel]) begin
          m_fv[sel]  = 1'b1;
          m_fop[sel] = op;
        end
      end
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] res, input logic z, input logic clr);
    if (sel == 0) begin
      bus_a.InValid = v; bus_a.ALUOp = alu_op_t'(op); bus_a.ALUSrcA = a; bus_a.ALUSrcB = b;
      bus_a.Result = res; bus_a.Zero = z; bus_a.Clear = clr;
    end else begin
      bus_b.InValid = v; bus_b.ALUOp = alu_op_t'(op); bus_b.ALUSrcA = a; bus_b.ALUSrcB = b;
      bus_b.Result = res; bus_b.Zero = z; bus_b.Clear = clr;
    end
  endtask

  task automatic sample(input int sel, output obs_t o);
    if (sel == 0) begin
      o.ready = bus_a.InReady; o.cv = bus_a.CheckValid; o.mis = bus_a.Mismatch;
      o.expd = bus_a.Expected; o.cnt = bus_a.CheckCount; o.err = bus_a.ErrCount;
      o.fv = bus_a.FirstErrValid; o.fop = bus_a.FirstErrOp;
    end else begin
      o.ready = bus_b.InReady; o.cv = bus_b.CheckValid; o.mis = bus_b.Mismatch;
      o.expd = bus_b.Expected; o.cnt = {5'b0, bus_b.CheckCount}; o.err = {5'b0, bus_b.ErrCount};
      o.fv = bus_b.FirstErrValid; o.fop = bus_b.FirstErrOp;
    end
  endtask

  // This task performs one complete transaction on the checker selected by sel.
  // fault 0: the ALU is correct.
  // fault 1: the ALU drives bad_res, with a consistent Zero flag.
  // fault 2: the result is correct, but the Zero flag is inverted.
  // When clr is set, Clear is held for the CHECK cycle, so it coincides with
  // the edge that produces the pulse.
  task automatic run_check(input int sel, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int fault, input logic [7:0] bad_res, input bit clr);
    obs_t       o;
    int         w;
    int         cycles;
    logic [7:0] exp_res;
    logic [7:0] drv_res;
    logic       drv_z;
    bit         exp_mis;

    exp_res = ref_alu(op, a, b);
    drv_res = (fault == 1) ? bad_res : exp_res;
    drv_z   = (fault == 2) ? (exp_res != 8'h00) : (drv_res == 8'h00);
    exp_mis = (drv_res != exp_res) || (drv_z != (exp_res == 8'h00));

    w = 0;
    @(negedge Clk);
    sample(sel, o);
    while (!o.ready && w < 20) begin
      @(negedge Clk);
      sample(sel, o);
      w++;
    end
    n_vec++;
    if (o.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait[%0d]: InReady=%b, required 1", sel, o.ready);
    end

    drive(sel, 1'b1, op, a, b, drv_res, drv_z, 1'b0);
    @(negedge Clk);
    drive(sel, 1'b0, op, a, b, drv_res, drv_z, 1'b0);
    cycles = 1;
    sample(sel, o);
    while (!o.cv && cycles < 20) begin
      drive(sel, 1'b0, op, a, b, drv_res, drv_z, clr && (cycles == settle[sel] + 1));
      @(negedge Clk);
      cycles++;
      sample(sel, o);
    end
    drive(sel, 1'b0, op, a, b, drv_res, drv_z, 1'b0);
    model_check(sel, op, exp_mis, clr);

    n_vec++;
    if (o.cv !== 1'b1) begin
      n_fail++;
      $display("FAIL pulse[%0d]: CheckValid never rose in %0d cycles", sel, cycles);
    end else if (cycles != settle[sel] + 2) begin
      n_fail++;
      $display("FAIL latency[%0d]: pulse in cycle %0d, required %0d", sel, cycles, settle[sel] + 2);
    end
    n_vec++;
    if (o.mis !== exp_mis) begin
      n_fail++;
      $display("FAIL mismatch[%0d] op=%0d a=%h b=%h: got %b, required %b", sel, op, a, b, o.mis, exp_mis);
    end
    n_vec++;
    if (o.expd !== exp_res) begin
      n_fail++;
      $display("FAIL expected[%0d] op=%0d a=%h b=%h: got %h, required %h", sel, op, a, b, o.expd, exp_res);
    end
    n_vec++;
    if (o.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_at_pulse[%0d]: got %b, required 1", sel, o.ready);
    end
    n_vec++;
    if (o.cnt !== 8'(m_cnt[sel]) || o.err !== 8'(m_err[sel])) begin
      n_fail++;
      $display("FAIL counts[%0d]: got chk=%0d err=%0d, required chk=%0d err=%0d",
               sel, o.cnt, o.err, m_cnt[sel], m_err[sel]);
    end
    n_vec++;
    if (o.fv !== m_fv[sel] || o.fop !== m_fop[sel]) begin
      n_fail++;
      $display("FAIL first_err[%0d]: got valid=%b op=%b, required valid=%b op=%b",
               sel, o.fv, o.fop, m_fv[sel], m_fop[sel]);
    end
    @(negedge Clk);
    sample(sel, o);
    n_vec++;
    if (o.cv !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_width[%0d]: CheckValid=%b one cycle later, required 0", sel, o.cv);
    end
  endtask

  task automatic test_reset();
    obs_t o;
    drive(0, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    ResetN = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    for (int s = 0; s < 2; s++) begin
      sample(s, o);
      n_vec++;
      if (o.ready !== 1'b1 || o.cv !== 1'b0 || o.mis !== 1'b0 || o.expd !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_flags[%0d]: ready=%b cv=%b mis=%b exp=%h, required 1 0 0 00",
                 s, o.ready, o.cv, o.mis, o.expd);
      end
      n_vec++;
      if (o.cnt !== 8'h00 || o.err !== 8'h00 || o.fv !== 1'b0 || o.fop !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_stats[%0d]: chk=%0d err=%0d fv=%b fop=%b, required all 0",
                 s, o.cnt, o.err, o.fv, o.fop);
      end
    end
    @(negedge Clk);
    ResetN = 1'b1;
  endtask

  task automatic test_op_sweep();
    for (int op = 0; op < 4; op++) run_check(0, 2'(op), 8'h11, 8'h11, 0, 8'h00, 1'b0);
  endtask

  task automatic test_mixed();
    for (int op = 0; op < 4; op++) run_check(0, 2'(op), 8'hF0, 8'h0F, 0, 8'h00, 1'b0);
    for (int op = 0; op < 4; op++) run_check(0, 2'(op), 8'hAA, 8'h55, 0, 8'h00, 1'b0);
  endtask

  task automatic test_fault();
    run_check(0, 2'b10, 8'h11, 8'h11, 1, 8'h22, 1'b0);
    run_check(0, 2'b11, 8'h11, 8'h11, 1, 8'h01, 1'b0);
    run_check(0, 2'b01, 8'hFF, 8'h01, 2, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back(input int sel);
    obs_t       o;
    int         period;
    logic [7:0] res;
    bit         edge_k;
    period = settle[sel] + 2;
    res    = ref_alu(2'b01, 8'h3C, 8'h05);
    @(negedge Clk);
    drive(sel, 1'b1, 2'b01, 8'h3C, 8'h05, res, res == 8'h00, 1'b0);
    for (int k = 1; k <= 3 * period; k++) begin
      @(negedge Clk);
      sample(sel, o);
      edge_k = (k % period) == 0;
      n_vec++;
      if (o.ready !== edge_k || o.cv !== edge_k) begin
        n_fail++;
        $display("FAIL b2b[%0d] cycle %0d: ready=%b cv=%b, required %b %b", sel, k, o.ready, o.cv, edge_k, edge_k);
      end
      if (edge_k) begin
        model_check(sel, 2'b01, 1'b0, 1'b0);
        n_vec++;
        if (o.mis !== 1'b0 || o.expd !== res) begin
          n_fail++;
          $display("FAIL b2b_result[%0d] cycle %0d: mis=%b exp=%h, required 0 %h", sel, k, o.mis, o.expd, res);
        end
      end
      if (k == 3 * period) drive(sel, 1'b0, 2'b01, 8'h3C, 8'h05, res, res == 8'h00, 1'b0);
    end
    n_vec++;
    if (o.cnt !== 8'(m_cnt[sel])) begin
      n_fail++;
      $display("FAIL b2b_count[%0d]: got %0d, required %0d", sel, o.cnt, m_cnt[sel]);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 9; i++) begin
      run_check(1, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), (i == 4) ? 1 : 0, 8'h5A, 1'b0);
    end
  endtask

  task automatic test_clear();
    run_check(1, 2'b01, 8'h10, 8'h20, 0, 8'h00, 1'b1);
    run_check(0, 2'b10, 8'h33, 8'h0F, 1, 8'h00, 1'b1);
    run_check(0, 2'b11, 8'h05, 8'h07, 1, 8'h00, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         f;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      f  = $urandom_range(0, 3);
      run_check(i % 2, op, a, b, (f == 3) ? 1 : (f == 2) ? 2 : 0,
                ref_alu(op, a, b) ^ 8'($urandom_range(1, 255)), $urandom_range(0, 9) == 0);
    end
  endtask

  task automatic test_mid_reset();
    obs_t o;
    @(negedge Clk);
    drive(0, 1'b1, 2'b01, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    @(negedge Clk);
    drive(0, 1'b0, 2'b01, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    sample(0, o);
    n_vec++;
    if (o.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL settle_busy: InReady=%b in SETTLE, required 0", o.ready);
    end
    #2 ResetN = 1'b0;
    #1 sample(0, o);
    model_reset();
    n_vec++;
    if (o.ready !== 1'b1 || o.cv !== 1'b0 || o.cnt !== 8'h00 || o.err !== 8'h00 || o.fv !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: ready=%b cv=%b chk=%0d err=%0d fv=%b, required 1 0 0 0 0",
               o.ready, o.cv, o.cnt, o.err, o.fv);
    end
    @(negedge Clk);
    ResetN = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      sample(0, o);
      n_vec++;
      if (o.cv !== 1'b0 || o.ready !== 1'b1) begin
        n_fail++;
        $display("FAIL post_reset cycle %0d: cv=%b ready=%b, required 0 1", k, o.cv, o.ready);
      end
    end
    run_check(0, 2'b00, 8'hC3, 8'h3C, 0, 8'h00, 1'b0);
  endtask

  initial begin
    test_reset();
    test_op_sweep();
    test_mixed();
    test_fault();
    test_back_to_back(0);
    test_back_to_back(1);
    test_saturation();
    test_clear();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_checker.md
Name: alu_checker

Overview:
- Synthesizable self-checking monitor on the ALU operand/result interface.
- Captures an issued ALUOp/ALUSrcA/ALUSrcB triple through a valid/ready handshake and waits a programmable settle time. It then compares the live ALU Result/Zero against a reference model and keeps pass/fail statistics.
- Sits beside the ALU in processor bring-up and in system benches. It reads what the operand driver writes.

Parameters:
- SETTLE_CYCLES, 2: clock cycles between capture and compare; legal range 1..15.
- CNT_W, 8: width of the check and error counters.

Ports:
- Clk  input  1  system clock, rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- InValid  input  1  operand triple is valid this cycle.
- InReady  output  1  checker can accept a triple.
- ALUOp  input  2  operation: 00 AND, 01 ADD, 10 XOR, 11 SUB.
- ALUSrcA  input  8  operand A.
- ALUSrcB  input  8  operand B.
- Result  input  8  ALU result under check.
- Zero  input  1  ALU zero flag under check.
- Clear  input  1  synchronous clear of counters and first-error record.
- CheckValid  output  1  one-cycle pulse when a compare completes.
- Mismatch  output  1  qualified by CheckValid; 1 = Result or Zero wrong.
- Expected  output  8  reference result of the last completed check.
- CheckCount  output  CNT_W  completed checks, saturating.
- ErrCount  output  CNT_W  mismatches, saturating.
- FirstErrValid  output  1  a mismatch has been recorded since reset/Clear.
- FirstErrOp  output  2  ALUOp of the first mismatch.

Behaviour:
- Reset (ResetN low, asynchronous): FSM to IDLE; InReady=1; all other outputs 0. Reset is effective mid-operation and the in-flight check is discarded.
- FSM states: IDLE, SETTLE, CHECK.
- IDLE:
  - InReady=1.
  - On InValid: latch ALUOp, ALUSrcA, ALUSrcB; load settle counter with SETTLE_CYCLES-1; go to SETTLE.
- SETTLE:
  - InReady=0.
  - Decrement counter; at 0 go to CHECK. With SETTLE_CYCLES=1, SETTLE lasts exactly one cycle.
  - InValid is ignored while not ready; the driver holds it until accepted.
- CHECK (one cycle):
  - Compute the reference from the latched operands. AND: A&B. ADD: (A+B) mod 256, carry dropped. XOR: A^B. SUB: (A-B) mod 256, two's complement, borrow dropped.
  - Zero reference = (reference == 0).
  - Mismatch = (Result != reference) OR (Zero != Zero reference).
  - Register outputs: CheckValid=1 and Mismatch valid one cycle after CHECK, i.e. capture-to-pulse latency = SETTLE_CYCLES+2 cycles. Expected is updated with the same registered pulse.
  - Return to IDLE; InReady is 1 in the cycle CheckValid is asserted.
- Result and Zero are sampled only in CHECK. The driver keeps the ALU inputs stable from handshake until CheckValid.
- Counters:
  - CheckCount increments on every check.
  - ErrCount increments on a mismatch.
  - Both saturate at 2^CNT_W-1 and never wrap.
- First-error record: FirstErrValid and FirstErrOp are set on the first mismatch only and held until Clear or reset.
- Clear:
  - Zeroes CheckCount, ErrCount, FirstErrValid and FirstErrOp next edge.
  - Does not affect FSM state or an in-flight check.
  - A check completing in the same cycle as Clear is not counted; Clear wins. CheckValid, Mismatch and Expected still pulse/update.

Decomposition:
- Shared package alu_pkg:
  - alu_op_t enum: OP_AND=2'b00, OP_ADD=2'b01, OP_XOR=2'b10, OP_SUB=2'b11.
  - DATA_W=8.
  - checker state enum.
- One sub-module alu_ref_model: combinational op, A, B -> expected result and expected zero. It is also reused by the ALU testbench scoreboard.

Test Plan:
- Correct op sweep: A=8'h11, B=8'h11, ops 00/01/10/11 against a correct ALU -> Expected 11/22/00/00; Zero ref 0/0/1/1; Mismatch=0 on all; CheckCount=4, ErrCount=0.
- Mixed operands: A=8'hF0, B=8'h0F -> Expected 00 (Zero=1), FF, FF, E1. Then A=8'hAA, B=8'h55 -> 00, FF, FF, 55. No mismatches; CheckCount=8.
- Fault injection: force Result=8'h22 on XOR of 11/11 -> Mismatch=1, ErrCount=1, FirstErrValid=1, FirstErrOp=2'b10. A later SUB fault leaves FirstErrOp=10.
- Latency and handshake:
  - With SETTLE_CYCLES=2, CheckValid rises 4 cycles after the accept edge.
  - With SETTLE_CYCLES=1, it rises 3 cycles after.
  - InValid held high continuously -> back-to-back accepts, InReady low exactly during SETTLE/CHECK.
- Clear/saturation: CNT_W=3, nine checks -> CheckCount sticks at 7. Clear coincident with CheckValid -> counters 0, pulse still seen.
- Mid-check reset: ResetN low during SETTLE -> outputs 0 asynchronously, no CheckValid pulse, InReady=1 after release.
